itf_port_arb: RTL

ITF_PORT_ARB -- requirements
Module: itf_port_arb

---
 rtl/itf_port_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/itf_port_arb.sv
// Two-requester (instruction/data) arbiter onto one multi-cycle memory port.
// Optional macro ARB_TIMEOUT_EN adds a busy-cycle watchdog that aborts with an error.
module itf_port_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_ack_o,
  output logic        inst_error_o,
  output logic [31:0] inst_data_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_ack_o,
  output logic        data_error_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  if (TIMEOUT_CYCLES < 32'd1 || TIMEOUT_CYCLES > 32'd65535) begin : g_param_check
    $error("itf_port_arb: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e      state_r;
  state_e      state_nxt_s;
  logic        last_grant_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [3:0]  mem_be_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        grant_inst_s;
  logic        grant_data_s;
  logic        busy_s;
  logic        done_s;
  logic        timeout_s;

  // On a tie the requester that did not win last time gets the port
  assign grant_inst_s = (state_r == IDLE) && inst_req_i &&
                        (!data_req_i || (last_grant_r == GRANT_DATA));
  assign grant_data_s = (state_r == IDLE) && data_req_i &&
                        (!inst_req_i || (last_grant_r == GRANT_INST));
  assign busy_s       = (state_r == INST_BUSY) || (state_r == DATA_BUSY);
  assign done_s       = busy_s && (mem_ack_i || timeout_s);

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 32'd1);
  logic [15:0] tmo_cnt_r;

  // Watchdog: counts busy cycles without a memory acknowledge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_r <= 16'd0;
    end else if (!busy_s) begin
      tmo_cnt_r <= 16'd0;
    end else if (!mem_ack_i) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // A real acknowledge in the expiry cycle wins over the abort
  assign timeout_s = busy_s && !mem_ack_i && (tmo_cnt_r == TIMEOUT_LIMIT);
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_inst_s) begin
          state_nxt_s = INST_BUSY;
        end else if (grant_data_s) begin
          state_nxt_s = DATA_BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INST_BUSY, DATA_BUSY: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, grant history and the registered memory command
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_DATA;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= 4'd0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_inst_s) begin
        last_grant_r <= GRANT_INST;
        mem_req_r    <= 1'b1;
        mem_we_r     <= 1'b0;
        mem_be_r     <= 4'hF;
        mem_addr_r   <= inst_addr_i;
        mem_wdata_r  <= 32'd0;
      end else if (grant_data_s) begin
        last_grant_r <= GRANT_DATA;
        mem_req_r    <= 1'b1;
        mem_we_r     <= data_we_i;
        mem_be_r     <= data_be_i;
        mem_addr_r   <= data_addr_i;
        mem_wdata_r  <= data_wdata_i;
      end else if (done_s) begin
        mem_req_r    <= 1'b0;
      end
    end
  end

  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_be_o    = mem_be_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;

  // Completion is steered only to the current owner; everything else stays zero
  always_comb begin
    inst_ack_o   = 1'b0;
    inst_error_o = 1'b0;
    inst_data_o  = 32'd0;
    data_ack_o   = 1'b0;
    data_error_o = 1'b0;
    data_rdata_o = 32'd0;
    if (done_s && (state_r == INST_BUSY)) begin
      inst_ack_o   = 1'b1;
      inst_error_o = mem_ack_i ? mem_error_i : 1'b1;
      inst_data_o  = mem_ack_i ? mem_rdata_i : 32'd0;
    end else if (done_s && (state_r == DATA_BUSY)) begin
      data_ack_o   = 1'b1;
      data_error_o = mem_ack_i ? mem_error_i : 1'b1;
      data_rdata_o = mem_ack_i ? mem_rdata_i : 32'd0;
    end else begin
      inst_ack_o = 1'b0;
    end
  end

endmodule
